// File: rtl/synth_pkg.sv
// synth_pkg: widths, midscale and scheduler states shared by the synth datapath blocks.
package synth_pkg;
    localparam int PHASE_W = 16;
    localparam int SINE_W = 11;
    localparam int AUDIO_W = 12;
    localparam logic [SINE_W-1:0] MIDSCALE = 11'd1024;
    typedef enum logic [1:0] {IDLE, SCAN, OUTPUT} state_e;
endpackage

// File: rtl/sample_tick_gen.sv
// sample_tick_gen: free-running 0..DIV-1 counter gated by ena; tick on the wrap cycle.
module sample_tick_gen #(
    parameter int DIV = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic ena,
    output logic tick
);
    localparam int CW = $clog2(DIV);
    logic [CW-1:0] cnt_q, cnt_d;
    assign tick = ena && (cnt_q == CW'(DIV - 1));
    always_comb cnt_d = !ena ? cnt_q : tick ? '0 : cnt_q + CW'(1);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/voice_scheduler.sv
// voice_scheduler: shares one sine lookup across NUM_VOICES phase accumulators, one voice
// per clock, and averages the voices into a 12-bit sample every SAMPLE_DIV clocks.
module voice_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int SAMPLE_DIV = 256,
    parameter int PHASE_W = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          ena,
    input  logic                          cfg_we,
    input  logic [$clog2(NUM_VOICES)-1:0] cfg_voice,
    input  logic [PHASE_W-1:0]            cfg_step,
    input  logic                          cfg_enable,
    output logic [7:0]                    period,
    input  logic [10:0]                   sine,
    output logic [11:0]                   audio,
    output logic                          sample_valid
);
    import synth_pkg::*;
    localparam int VW = $clog2(NUM_VOICES);
    localparam int ACC_W = SINE_W + VW;
    state_e state_q, state_d;
    logic [PHASE_W-1:0] phase_q [NUM_VOICES];
    logic [PHASE_W-1:0] step_q [NUM_VOICES];
    logic [NUM_VOICES-1:0] en_q;
    logic [VW-1:0] v_q;
    logic [ACC_W-1:0] acc_q;
    logic [7:0] period_q, cur;
    logic [AUDIO_W-1:0] audio_q;
    logic valid_q, tick, scan, last;
    sample_tick_gen #(.DIV(SAMPLE_DIV)) u_tick (
        .clk (clk),
        .rst (rst),
        .ena (ena),
        .tick(tick)
    );
    assign scan = state_q == SCAN;
    assign last = v_q == VW'(NUM_VOICES - 1);
    assign cur = phase_q[v_q][PHASE_W-1 -: 8];
    // Lookup is zero-latency: period is driven live during SCAN and held otherwise.
    assign period = scan ? cur : period_q;
    assign audio = audio_q;
    assign sample_valid = valid_q;
    always_comb begin
        state_d = state_q == IDLE ? (tick ? SCAN : IDLE) :
                  scan ? (last ? OUTPUT : SCAN) : IDLE;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else state_q <= state_d;
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            v_q <= '0;
            acc_q <= '0;
            period_q <= '0;
            audio_q <= 12'h800;
            valid_q <= 1'b0;
            en_q <= '0;
            for (int i = 0; i < NUM_VOICES; i++) begin
                phase_q[i] <= '0;
                step_q[i] <= '0;
            end
        end else begin
            if (state_q == IDLE && tick) acc_q <= '0;
            if (scan) begin
                acc_q <= acc_q + ACC_W'(en_q[v_q] ? sine : MIDSCALE);
                v_q <= v_q + VW'(1);
                period_q <= cur;
            end
            if (state_q == OUTPUT) audio_q <= {acc_q[ACC_W-1 -: SINE_W], 1'b0};
            valid_q <= state_q == OUTPUT;
            // A config write lands on the same edge as a scan update; the write wins.
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (cfg_we && cfg_voice == VW'(i)) begin
                    step_q[i] <= cfg_step;
                    en_q[i] <= cfg_enable;
                end
                if (cfg_we && cfg_voice == VW'(i) && cfg_enable && !en_q[i])
                    phase_q[i] <= '0;
                else if (scan && v_q == VW'(i) && en_q[i])
                    phase_q[i] <= phase_q[i] + step_q[i];
            end
        end
    end
endmodule

// File: tb/tb_voice_scheduler.sv
// tb_voice_scheduler: directed checks of reset, per-voice scan, wrap, write collision, ena and reset abort.
module tb_voice_scheduler;
    logic clk = 0, rst = 0, ena = 0, cfg_we = 0, cfg_enable = 0;
    logic [1:0] cfg_voice = 0;
    logic [15:0] cfg_step = 0;
    logic [7:0] period;
    logic [10:0] sine;
    logic [11:0] audio;
    logic sample_valid;
    int tests = 0, fails = 0, kk = 0;

    always #5 clk = ~clk;
    // Stand-in lookup: a simple ramp so each period value gives a distinct, hand-computable sample.
    assign sine = 11'(100 + 5 * period);

    voice_scheduler dut (
        .clk(clk), .rst(rst), .ena(ena), .cfg_we(cfg_we), .cfg_voice(cfg_voice),
        .cfg_step(cfg_step), .cfg_enable(cfg_enable), .period(period), .sine(sine),
        .audio(audio), .sample_valid(sample_valid)
    );

    // kk tracks the cycle position within the frame: the valid pulse is cycle 5 after the tick edge.
    task automatic step();
        @(negedge clk);
        kk = sample_valid ? 5 : kk + 1;
    endtask

    task automatic cfg_write(input int v, input logic [15:0] s, input logic en);
        cfg_voice = 2'(v); cfg_step = s; cfg_enable = en; cfg_we = 1;
        step();
        cfg_we = 0;
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!sample_valid && n < 1000);
    endtask

    task automatic scan_frame(input bit wr, input int wv, input logic [15:0] ws, input logic wen,
                              output logic [3:0][7:0] p, output logic [11:0] a, output bit ok);
        int n = 0;
        while (kk != 256 && n < 600) begin
            step();
            n++;
        end
        for (int v = 0; v < 4; v++) begin
            p[v] = period;
            if (wr && wv == v) begin
                cfg_voice = 2'(v); cfg_step = ws; cfg_enable = wen; cfg_we = 1;
            end
            step();
            cfg_we = 0;
        end
        step();
        ok = sample_valid === 1'b1 && n < 600;
        a = audio;
    endtask

    task automatic check_frame(input string name, input bit wr, input int wv, input logic [15:0] ws,
                               input logic wen, input logic [31:0] ep, input logic [11:0] ea);
        logic [3:0][7:0] p;
        logic [11:0] a;
        bit ok;
        scan_frame(wr, wv, ws, wen, p, a, ok);
        tests++;
        if (!ok) begin fails++; $display("FAIL %s timing: valid not at scan+5", name); end
        tests++;
        if (p !== ep) begin fails++; $display("FAIL %s period: got %h want %h", name, p, ep); end
        tests++;
        if (a !== ea) begin fails++; $display("FAIL %s audio: got %h want %h", name, a, ea); end
    endtask

    task automatic test_reset();
        int n;
        rst = 0; ena = 0;
        repeat (3) step();
        tests++;
        if (audio !== 12'h800 || sample_valid !== 0 || period !== 0) begin
            fails++;
            $display("FAIL reset_vals: audio=%h valid=%b period=%h want 800/0/00", audio, sample_valid, period);
        end
        rst = 1; ena = 1;
        wait_valid(n);
        tests++;
        if (n !== 261) begin fails++; $display("FAIL first_sample_time: got %0d want 261", n); end
        tests++;
        if (audio !== 12'h800) begin fails++; $display("FAIL all_off_audio: got %h want 800", audio); end
        wait_valid(n);
        tests++;
        if (n !== 256) begin fails++; $display("FAIL sample_spacing: got %0d want 256", n); end
        tests++;
        if (audio !== 12'h800) begin fails++; $display("FAIL all_off_audio2: got %h want 800", audio); end
    endtask

    task automatic test_single_voice();
        cfg_write(0, 16'h0100, 1);
        check_frame("v0_f0", 0, 0, 0, 0, 32'h0000_0000, 12'h632);
        check_frame("v0_f1", 0, 0, 0, 0, 32'h0000_0001, 12'h634);
        check_frame("v0_f2", 0, 0, 0, 0, 32'h0000_0002, 12'h636);
    endtask

    task automatic test_wrap();
        cfg_write(0, 16'h0100, 0);
        cfg_write(1, 16'hFFFF, 1);
        check_frame("wrap_f0", 0, 0, 0, 0, 32'h0000_0003, 12'h632);
        check_frame("wrap_f1", 0, 0, 0, 0, 32'h0000_FF03, 12'h8AE);
        check_frame("wrap_f2", 0, 0, 0, 0, 32'h0000_FF03, 12'h8AE);
    endtask

    task automatic test_collision();
        cfg_write(1, 16'hFFFF, 0);
        cfg_write(2, 16'h0100, 1);
        check_frame("col_a", 0, 0, 0, 0, 32'h0000_FF03, 12'h632);
        check_frame("col_b", 1, 2, 16'h0200, 1, 32'h0001_FF03, 12'h634);
        check_frame("col_c", 0, 0, 0, 0, 32'h0002_FF03, 12'h636);
        check_frame("col_d", 0, 0, 0, 0, 32'h0004_FF03, 12'h63C);
        cfg_write(2, 16'h0200, 0);
        cfg_write(2, 16'h0200, 1);
        check_frame("reenable", 0, 0, 0, 0, 32'h0000_FF03, 12'h632);
    endtask

    task automatic test_ena_drop();
        int n = 0, pulses = 0;
        while (kk != 256 && n < 600) begin step(); n++; end
        ena = 0;
        n = 0;
        do begin step(); n++; end while (!sample_valid && n < 20);
        tests++;
        if (n !== 5) begin fails++; $display("FAIL ena_drop_complete: valid after %0d want 5", n); end
        tests++;
        if (audio !== 12'h636) begin fails++; $display("FAIL ena_drop_audio: got %h want 636", audio); end
        repeat (600) begin step(); if (sample_valid) pulses++; end
        tests++;
        if (pulses !== 0) begin fails++; $display("FAIL ena_low_pulses: got %0d want 0", pulses); end
        ena = 1;
        wait_valid(n);
        tests++;
        if (n !== 261) begin fails++; $display("FAIL ena_resume_time: got %0d want 261", n); end
        tests++;
        if (audio !== 12'h63C) begin fails++; $display("FAIL ena_resume_audio: got %h want 63C", audio); end
    endtask

    task automatic test_reset_mid_scan();
        int n = 0;
        while (kk != 257 && n < 600) begin step(); n++; end
        rst = 0;
        #1;
        tests++;
        if (audio !== 12'h800 || sample_valid !== 0 || period !== 0) begin
            fails++;
            $display("FAIL async_reset: audio=%h valid=%b period=%h want 800/0/00", audio, sample_valid, period);
        end
        repeat (2) step();
        rst = 1;
        wait_valid(n);
        tests++;
        if (n !== 261) begin fails++; $display("FAIL post_reset_time: got %0d want 261", n); end
        tests++;
        if (audio !== 12'h800) begin fails++; $display("FAIL post_reset_audio: got %h want 800", audio); end
    endtask

    initial begin
        test_reset();
        test_single_voice();
        test_wrap();
        test_collision();
        test_ena_drop();
        test_reset_mid_scan();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/voice_scheduler.md
# voice_scheduler

Time-multiplexes the single shared `sine_wave_generator` lookup across `NUM_VOICES` oscillator voices, producing one mixed 12-bit sample per sample period for `audio_pwm_generator`. Holds per-voice phase accumulators and step (pitch) registers, sequences the lookup one voice per clock, and averages the results into `audio`. Sits between the note/config front end and the PWM output stage.

## Interface
- `NUM_VOICES`, 4: voice count; power of two, 2..16.
- `SAMPLE_DIV`, 256: clk cycles per output sample (12 MHz / 256 ≈ 46.9 kHz); must be ≥ `NUM_VOICES`+2.
- `PHASE_W`, 16: phase accumulator width.
- `clk` in 1: system clock (12 MHz).
- `rst` in 1: reset, asynchronous, active-low (asserted at 0).
- `ena` in 1: enables sample tick generation.
- `cfg_we` in 1: config write strobe, one cycle.
- `cfg_voice` in $clog2(NUM_VOICES): voice index for the write.
- `cfg_step` in PHASE_W: phase increment per sample.
- `cfg_enable` in 1: voice on/off.
- `period` out 8: phase index to the sine generator, `phase[v][PHASE_W-1 -: 8]`.
- `sine` in 11: unsigned offset-binary lookup result (midscale 1024), combinational from `period`.
- `audio` out 12: mixed sample to the PWM generator.
- `sample_valid` out 1: one-cycle pulse when `audio` updates.

## Operation
- Reset: `audio`=12'h800, `sample_valid`=0, `period`=0, all phases/steps/enables 0, tick counter 0, state IDLE.
- Tick counter counts 0..SAMPLE_DIV-1 while `ena`=1, holds while `ena`=0; tick asserted on count SAMPLE_DIV-1 (wraps to 0).
- FSM: IDLE → (tick) SCAN → after voice NUM_VOICES-1 → OUTPUT → IDLE.
- SCAN, voice index v = 0..N-1, one per cycle: drive `period` from phase[v]; acc += enable[v] ? `sine` : 1024; phase[v] += step[v] if enable[v] (mod 2^PHASE_W, wrap silent).
- acc width 11+log2(N), cleared on entry to SCAN.
- OUTPUT: `audio` <= {acc >> log2(N), 1'b0}; `sample_valid`=1 for that cycle.
- Disabled voices contribute midscale, so all-off gives `audio`=12'h800 (no DC step on note off).
- Config write: step[cfg_voice] <= cfg_step, enable[cfg_voice] <= cfg_enable; on enable 0→1 phase cleared to 0.
- Write in the cycle voice v is scanned: scan uses pre-write step/enable/phase; register write wins (phase clear overrides increment).
- `ena` falling mid-frame: current frame completes through OUTPUT; no new tick until `ena`=1.
- `rst` asserted mid-frame: immediate return to reset values; partial frame discarded.
- `period` held at last value outside SCAN.

## Timing
- Tick at edge T: SCAN occupies cycles T+1..T+N; `audio`/`sample_valid` update at edge T+N+1.
- Sample spacing exactly SAMPLE_DIV cycles while `ena` held high.
- `sine` sampled same cycle as `period` drive (zero-latency lookup); no pipeline register in between.
- Config write takes effect for the next voice scan that starts after the write edge.

## Structure
- Shared package `synth_pkg`: PHASE_W, SINE_W=11, AUDIO_W=12, MIDSCALE=11'd1024, state enum {IDLE, SCAN, OUTPUT}.
- Sub-module `sample_tick_gen` (SAMPLE_DIV counter, `ena` gate, tick output); reused by other synth blocks.
- Sine generator instantiated outside; this block only drives `period`/samples `sine`.

## Test plan
- Reset: hold `rst`=0, check `audio`=0x800, `sample_valid`=0, `period`=0; release, all voices off → every sample 0x800, `sample_valid` every 256 cycles.
- Voice 0 step=0x0100 enabled, others off: `period` during voice-0 scan reads 0,1,2,... on successive samples; `audio` = {(sine+3·1024)>>2, 0}.
- Wrap: voice 1 step=0xFFFF after enable → phase 0, 0xFFFF, 0xFFFE...; `period` 0x00, 0xFF, 0xFF, no glitch.
- Collision: write voice 2 step=0x0200 in its scan cycle → that frame uses old step, next frame new step; re-enable clears phase to 0.
- `ena` dropped one cycle after tick → frame still completes, `sample_valid` at T+N+1, then no further pulses until `ena`=1.
- `rst` asserted during SCAN → outputs return to reset values asynchronously; first post-reset sample is 0x800.
